// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : snn_pkg
//  Purpose : Shared definitions for the synaptic update path: default
//            network dimensions (also used by fire_fifo and the weight RAM),
//            the scheduler state encoding and the weight-address packing.
//  Revision: 1.0  initial release
// ============================================================================
package snn_pkg;

  // Default network dimensions; c_num_neurons must equal 2**c_tag_bits.
  localparam int c_num_neurons = 2;
  localparam int c_tag_bits    = 1;
  localparam int c_w_bits      = 8;

  // Scheduler states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Weight RAM address: source tag in the upper half, destination index in
  // the lower half, so each source owns a contiguous fan-out row.
  function automatic logic [2*c_tag_bits-1:0] pack_waddr(
    input logic [c_tag_bits-1:0] src,
    input logic [c_tag_bits-1:0] dst
  );
    return {src, dst};
  endfunction

endpackage
`default_nettype wire

// File: rtl/synaptic_update_sched.sv
`default_nettype none
// ============================================================================
//  Module  : synaptic_update_sched
//  Purpose : Synaptic update phase sequencer. Drains fired-neuron tags from
//            fire_fifo, reads each source's fan-out row from the weight RAM
//            and issues one accumulate request per target neuron.
//  Revision: 1.0  initial release
//
//  Ports
//    clk          in   system clock, all state on rising edge
//    syn_reset_n  in   synchronous active-low reset
//    start        in   one-cycle pulse, begin phase (only honoured in IDLE)
//    busy         out  high in every state except IDLE
//    done         out  one-cycle pulse, phase complete
//    spike_count  out  spikes processed since last start (saturating)
//    fifo_empty   in   fire_fifo empty flag
//    fifo_tag     in   fire_fifo head tag
//    fifo_deq     out  fire_fifo dequeue strobe
//    w_rd         out  weight RAM read enable
//    w_addr       out  weight RAM address {src_tag, dst_idx}
//    w_data       in   weight RAM data, valid the cycle after w_rd
//    acc_valid    out  accumulate request valid
//    acc_ready    in   accumulator accepts this cycle
//    acc_tag      out  target neuron index
//    acc_weight   out  weight to add
//    acc_last     out  request targets the last neuron of the row
// ============================================================================
module synaptic_update_sched
  import snn_pkg::*;
#(
  parameter int NUMNEURONS = c_num_neurons,
  parameter int TAGBITS    = c_tag_bits,
  parameter int WBITS      = c_w_bits
) (
  input  logic                 clk,
  input  logic                 syn_reset_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [TAGBITS:0]     spike_count,
  input  logic                 fifo_empty,
  input  logic [TAGBITS-1:0]   fifo_tag,
  output logic                 fifo_deq,
  output logic                 w_rd,
  output logic [2*TAGBITS-1:0] w_addr,
  input  logic [WBITS-1:0]     w_data,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic [TAGBITS-1:0]   acc_tag,
  output logic [WBITS-1:0]     acc_weight,
  output logic                 acc_last
);

  localparam logic [TAGBITS-1:0] c_last_idx = TAGBITS'(NUMNEURONS - 1);
  localparam logic [TAGBITS:0]   c_sat      = (TAGBITS + 1)'(NUMNEURONS);

  state_t               r_state;
  logic [TAGBITS-1:0]   r_src_tag;
  logic [TAGBITS-1:0]   r_issue_j;
  logic [TAGBITS:0]     r_spike_count;
  logic                 r_acc_valid;
  logic [TAGBITS-1:0]   r_acc_tag;

  logic                 w_stall;
  logic                 w_issue;
  logic [TAGBITS-1:0]   w_dst;
  logic [2*TAGBITS-1:0] w_addr_raw;

  // A stalled request keeps re-reading its own word so acc_weight, which is
  // taken straight from the RAM output, stays stable until accepted.
  assign w_stall = r_acc_valid & ~acc_ready;
  assign w_issue = (r_state == ST_SCAN) & ~w_stall;
  assign w_dst   = w_stall ? r_acc_tag : r_issue_j;

  generate
    if (TAGBITS == c_tag_bits) begin : g_pack_helper
      assign w_addr_raw = pack_waddr(r_src_tag, w_dst);
    end else begin : g_pack_concat
      assign w_addr_raw = {r_src_tag, w_dst};
    end
  endgenerate

  assign w_rd        = w_issue | w_stall;
  assign w_addr      = w_rd ? w_addr_raw : '0;
  assign fifo_deq    = (r_state == ST_FETCH) & ~fifo_empty;
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign spike_count = r_spike_count;
  assign acc_valid   = r_acc_valid;
  assign acc_tag     = r_acc_tag;
  assign acc_weight  = w_data;
  assign acc_last    = r_acc_valid & (r_acc_tag == c_last_idx);

  always_ff @(posedge clk) begin
    if (!syn_reset_n) begin
      r_state       <= ST_IDLE;
      r_src_tag     <= '0;
      r_issue_j     <= '0;
      r_spike_count <= '0;
      r_acc_valid   <= 1'b0;
      r_acc_tag     <= '0;
    end else begin
      // Request pipeline: a read issued this cycle becomes a request next
      // cycle; while stalled the current request is simply held.
      if (!w_stall) begin
        r_acc_valid <= w_issue;
        if (w_issue) begin
          r_acc_tag <= r_issue_j;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_spike_count <= '0;
            r_state       <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (fifo_empty) begin
            r_state <= ST_DONE;
          end else begin
            r_src_tag <= fifo_tag;
            r_issue_j <= '0;
            if (r_spike_count != c_sat) begin
              r_spike_count <= r_spike_count + (TAGBITS + 1)'(1);
            end
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_issue) begin
            r_issue_j <= r_issue_j + TAGBITS'(1);
            if (r_issue_j == c_last_idx) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Only the last request of the row can be outstanding here.
          if (r_acc_valid && acc_ready) begin
            r_state <= ST_FETCH;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_synaptic_update_sched.sv
`default_nettype none
// ============================================================================
//  Module  : tb_synaptic_update_sched
//  Purpose : Directed self-checking bench for synaptic_update_sched with a
//            small fire_fifo model and a registered-read weight RAM model.
//            Weight RAM contents: W[0][0]=0, W[0][1]=7, W[1][0]=5, W[1][1]=9.
//  Revision: 1.0  initial release
// ============================================================================
module tb_synaptic_update_sched;

  logic       clk = 1'b0;
  logic       syn_reset_n;
  logic       start;
  logic       busy;
  logic       done;
  logic [1:0] spike_count;
  logic       fifo_empty;
  logic [0:0] fifo_tag;
  logic       fifo_deq;
  logic       w_rd;
  logic [1:0] w_addr;
  logic [7:0] w_data = 8'd0;
  logic       acc_valid;
  logic       acc_ready;
  logic [0:0] acc_tag;
  logic [7:0] acc_weight;
  logic       acc_last;

  synaptic_update_sched #(
    .NUMNEURONS(2),
    .TAGBITS   (1),
    .WBITS     (8)
  ) dut (
    .clk        (clk),
    .syn_reset_n(syn_reset_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .spike_count(spike_count),
    .fifo_empty (fifo_empty),
    .fifo_tag   (fifo_tag),
    .fifo_deq   (fifo_deq),
    .w_rd       (w_rd),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_tag    (acc_tag),
    .acc_weight (acc_weight),
    .acc_last   (acc_last)
  );

  always #5 clk = ~clk;

  // Weight RAM: registered read.
  logic [7:0] wmem [4];
  always @(posedge clk) if (w_rd) w_data <= wmem[w_addr];

  // fire_fifo: initial block writes, monitor pops.
  logic [0:0] fifo_mem [4];
  logic [2:0] wr_ptr = 3'd0;
  logic [2:0] rd_ptr = 3'd0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_tag   = fifo_mem[rd_ptr[1:0]];

  int deq_cnt  = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  always @(posedge clk) begin
    if (fifo_deq) begin
      rd_ptr  <= rd_ptr + 3'd1;
      deq_cnt <= deq_cnt + 1;
    end
    if (acc_valid && acc_ready) acc_cnt <= acc_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int d0, a0, k0, cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic t);
    fifo_mem[wr_ptr[1:0]] = t;
    wr_ptr = wr_ptr + 3'd1;
  endtask

  initial begin
    wmem[0] = 8'd0; wmem[1] = 8'd7; wmem[2] = 8'd5; wmem[3] = 8'd9;
    fifo_mem[0] = 1'b0; fifo_mem[1] = 1'b0; fifo_mem[2] = 1'b0; fifo_mem[3] = 1'b0;
    syn_reset_n = 1'b0;
    start       = 1'b0;
    acc_ready   = 1'b1;

    // ---------------- reset state
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_deq", fifo_deq, 1'b0);
    check("rst_wrd", w_rd, 1'b0);
    check("rst_accv", acc_valid, 1'b0);
    check("rst_cnt", spike_count, 2'd0);
    syn_reset_n = 1'b1;
    tick();

    // ---------------- empty fifo
    d0 = deq_cnt;
    start = 1'b1; tick(); start = 1'b0;                 // c1 FETCH
    check("empty_c1_busy", busy, 1'b1);
    check("empty_c1_deq", fifo_deq, 1'b0);
    check("empty_c1_wrd", w_rd, 1'b0);
    check("empty_c1_done", done, 1'b0);
    tick();                                             // c2 DONE
    check("empty_c2_done", done, 1'b1);
    check("empty_c2_cnt", spike_count, 2'd0);
    tick();                                             // c3 IDLE
    check("empty_c3_busy", busy, 1'b0);
    check("empty_c3_done", done, 1'b0);
    check("empty_deqs", deq_cnt - d0, 0);

    // ---------------- one spike, tag 1
    push(1'b1);
    start = 1'b1; tick(); start = 1'b0;                 // c1
    check("one_c1_deq", fifo_deq, 1'b1);
    tick();                                             // c2
    check("one_c2_wrd", w_rd, 1'b1);
    check("one_c2_addr", w_addr, 2'd2);
    check("one_c2_accv", acc_valid, 1'b0);
    tick();                                             // c3
    check("one_c3_addr", w_addr, 2'd3);
    check("one_c3_accv", acc_valid, 1'b1);
    check("one_c3_tag", acc_tag, 1'b0);
    check("one_c3_wt", acc_weight, 8'd5);
    check("one_c3_last", acc_last, 1'b0);
    tick();                                             // c4 DRAIN
    check("one_c4_accv", acc_valid, 1'b1);
    check("one_c4_tag", acc_tag, 1'b1);
    check("one_c4_wt", acc_weight, 8'd9);
    check("one_c4_last", acc_last, 1'b1);
    check("one_c4_wrd", w_rd, 1'b0);
    tick();                                             // c5 FETCH, empty
    check("one_c5_deq", fifo_deq, 1'b0);
    check("one_c5_done", done, 1'b0);
    check("one_c5_accv", acc_valid, 1'b0);
    tick();                                             // c6 DONE
    check("one_c6_done", done, 1'b1);
    check("one_c6_cnt", spike_count, 2'd1);
    tick();                                             // c7 IDLE
    check("one_c7_busy", busy, 1'b0);
    check("one_c7_cnt", spike_count, 2'd1);

    // ---------------- two spikes, tags 0 then 1
    d0 = deq_cnt; a0 = acc_cnt;
    push(1'b0); push(1'b1);
    start = 1'b1; tick(); start = 1'b0;                 // c1
    check("two_c1_deq", fifo_deq, 1'b1);
    tick();                                             // c2
    check("two_c2_addr", w_addr, 2'd0);
    tick();                                             // c3
    check("two_c3_addr", w_addr, 2'd1);
    check("two_c3_tag", acc_tag, 1'b0);
    check("two_c3_wt", acc_weight, 8'd0);
    check("two_c3_accv", acc_valid, 1'b1);
    tick();                                             // c4
    check("two_c4_tag", acc_tag, 1'b1);
    check("two_c4_wt", acc_weight, 8'd7);
    check("two_c4_last", acc_last, 1'b1);
    tick();                                             // c5
    check("two_c5_deq", fifo_deq, 1'b1);
    tick();                                             // c6
    check("two_c6_addr", w_addr, 2'd2);
    tick();                                             // c7
    check("two_c7_tag", acc_tag, 1'b0);
    check("two_c7_wt", acc_weight, 8'd5);
    tick();                                             // c8
    check("two_c8_tag", acc_tag, 1'b1);
    check("two_c8_wt", acc_weight, 8'd9);
    tick();                                             // c9
    check("two_c9_done", done, 1'b0);
    tick();                                             // c10
    check("two_c10_done", done, 1'b1);
    check("two_c10_cnt", spike_count, 2'd2);
    check("two_deqs", deq_cnt - d0, 2);
    check("two_accs", acc_cnt - a0, 4);
    tick();

    // ---------------- backpressure on first request
    a0 = acc_cnt;
    push(1'b1);
    start = 1'b1; tick(); start = 1'b0;                 // c1
    tick();                                             // c2
    check("bp_c2_addr", w_addr, 2'd2);
    tick();                                             // c3
    acc_ready = 1'b0; #1;
    check("bp_c3_accv", acc_valid, 1'b1);
    check("bp_c3_wrd", w_rd, 1'b1);
    check("bp_c3_addr", w_addr, 2'd2);
    tick();                                             // c4
    check("bp_c4_accv", acc_valid, 1'b1);
    check("bp_c4_tag", acc_tag, 1'b0);
    check("bp_c4_wt", acc_weight, 8'd5);
    check("bp_c4_addr", w_addr, 2'd2);
    tick();                                             // c5
    check("bp_c5_tag", acc_tag, 1'b0);
    check("bp_c5_wt", acc_weight, 8'd5);
    check("bp_c5_addr", w_addr, 2'd2);
    tick();                                             // c6
    acc_ready = 1'b1; #1;
    check("bp_c6_tag", acc_tag, 1'b0);
    check("bp_c6_wt", acc_weight, 8'd5);
    check("bp_c6_addr", w_addr, 2'd3);
    tick();                                             // c7 DRAIN
    check("bp_c7_tag", acc_tag, 1'b1);
    check("bp_c7_wt", acc_weight, 8'd9);
    check("bp_c7_last", acc_last, 1'b1);
    tick();                                             // c8 FETCH
    check("bp_c8_accv", acc_valid, 1'b0);
    tick();                                             // c9 DONE
    check("bp_c9_done", done, 1'b1);
    check("bp_accs", acc_cnt - a0, 2);
    tick();

    // ---------------- reset in SCAN, then clean restart
    d0 = deq_cnt;
    push(1'b0);
    start = 1'b1; tick(); start = 1'b0;                 // c1
    tick();                                             // c2 SCAN
    check("rs_c2_wrd", w_rd, 1'b1);
    syn_reset_n = 1'b0;
    tick();                                             // c3 reset taken
    check("rs_busy", busy, 1'b0);
    check("rs_wrd", w_rd, 1'b0);
    check("rs_accv", acc_valid, 1'b0);
    check("rs_deq", fifo_deq, 1'b0);
    check("rs_done", done, 1'b0);
    check("rs_cnt", spike_count, 2'd0);
    check("rs_deqs", deq_cnt - d0, 1);
    syn_reset_n = 1'b1;
    tick();
    push(1'b1);
    start = 1'b1; tick(); start = 1'b0;                 // c1
    check("rs2_c1_deq", fifo_deq, 1'b1);
    tick();                                             // c2
    check("rs2_c2_addr", w_addr, 2'd2);
    tick();                                             // c3
    check("rs2_c3_wt", acc_weight, 8'd5);
    tick();                                             // c4
    check("rs2_c4_last", acc_last, 1'b1);
    tick(); tick();                                     // c6
    check("rs2_c6_done", done, 1'b1);
    check("rs2_c6_cnt", spike_count, 2'd1);
    tick();

    // ---------------- start while busy, three spikes (saturation)
    d0 = deq_cnt; a0 = acc_cnt; k0 = done_cnt;
    push(1'b0); push(1'b1); push(1'b1);
    start = 1'b1; tick(); start = 1'b0;                 // c1
    tick();                                             // c2
    tick();                                             // c3
    start = 1'b1;
    tick();                                             // c4
    start = 1'b0;
    check("sb_c4_busy", busy, 1'b1);
    check("sb_c4_cnt", spike_count, 2'd1);
    tick(); tick();                                     // c6
    check("sb_c6_cnt", spike_count, 2'd2);
    cyc = 6;
    for (int i = 0; i < 30; i++) begin
      if (done) break;
      tick();
      cyc++;
    end
    check("sb_done_seen", done, 1'b1);
    check("sb_done_cycle", cyc, 14);
    check("sb_sat_cnt", spike_count, 2'd2);
    check("sb_deqs", deq_cnt - d0, 3);
    check("sb_accs", acc_cnt - a0, 6);
    tick(); tick();
    check("sb_done_pulses", done_cnt - k0, 1);
    check("sb_hold_cnt", spike_count, 2'd2);
    check("sb_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
